veririsc_sequencer: RTL and testbench
=====================================

Name: veririsc_sequencer

Overview:
- Upstream stage of the VeriRISC controller. Generates the 3-bit instruction phase and holds the instruction register, from which it presents opcode and operand. Also holds the registered zero flag and the halt/resume state.
- Outputs phase, opcode and zero drive the controller's combinational decode directly.
- Consumes the controller's halt, ld_ir and ld_ac strobes, plus the memory data bus and the accumulator's next value.

Parameters:
- DWIDTH, 8, data bus / instruction word width
- OPWIDTH, 3, opcode field width (instruction bits DWIDTH-1 down to DWIDTH-OPWIDTH)
- AWIDTH, 5, operand/address field width (AWIDTH = DWIDTH - OPWIDTH; elaboration error otherwise)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- ena  input  1  step enable; when 0 all state holds (rst still acts)
- go  input  1  resume pulse; leaves HALTED state
- halt  input  1  controller halt strobe
- ld_ir  input  1  controller IR load strobe
- ld_ac  input  1  controller accumulator load strobe
- data_in  input  DWIDTH  memory read data (instruction source)
- ac_next  input  DWIDTH  value the accumulator loads on this edge
- phase  output  3  current phase, 0..7
- opcode  output  OPWIDTH  IR[DWIDTH-1:AWIDTH]
- operand  output  AWIDTH  IR[AWIDTH-1:0]
- zero  output  1  registered accumulator-is-zero flag
- halted  output  1  CPU is in HALTED state

Behaviour:
- Reset (rst=1 at rising clk, regardless of ena):
  - phase=0, IR=0 (so opcode=0, operand=0), zero=1, halted=0.
  - Reset wins over every other input. Reset mid-instruction or while halted returns directly to RUN with phase 0.
- FSM has two states:
  - RUN: on each clk with ena=1, phase <= phase+1 modulo 8 (7 -> 0 wraps).
  - HALTED: phase held at 5 and not advanced. Phase 5 is chosen because with a HLT opcode the controller asserts neither inc_pc nor ld_pc there, so the PC is stable.
- RUN -> HALTED:
  - Occurs when ena=1, phase==4 and halt=1.
  - On that edge: phase <= 5, halted <= 1.
  - halt is sampled only at phase 4 and ignored in all other phases.
- HALTED -> RUN:
  - Occurs when ena=1 and go=1.
  - On that edge: halted <= 0 and phase <= 6; execution then continues 6, 7, 0.
  - go is ignored in RUN.
  - If halt and go are both 1 at phase 4 in RUN, halt wins; a go must arrive in a later cycle.
- IR:
  - When ena=1 and ld_ir=1, IR <= data_in.
  - ld_ir is high in phases 2 and 3, so the IR loads on two consecutive edges; the second load overwrites the first with the same stable data.
  - IR is not loaded while halted (the controller does not assert ld_ir there).
- Zero flag:
  - When ena=1 and ld_ac=1, zero <= (ac_next == 0).
  - Otherwise zero holds. It is not updated by STO, SKZ or JMP.
- ena=0 freezes phase, IR, zero and halted. go, halt, ld_ir and ld_ac are ignored that cycle.
- All outputs are registered and none is a combinational function of inputs, so controller decode has no combinational loop back through halt.
- Latency:
  - IR change is visible on opcode/operand one cycle after the ld_ir edge.
  - zero is valid from phase 0 of the next instruction.

Decomposition:
- Shared package veririsc_pkg:
  - opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - phase constants INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
  - the RUN/HALTED state encoding.
- One sub-module is natural: veririsc_phase_counter (3-bit counter with enable, synchronous load and hold). The FSM, IR and zero register stay in the top of this block.

Test Plan:
- Reset then ena=1 for 10 cycles, no halt -> phase goes 0,1,...,7,0,1; halted=0; zero=1.
- ld_ir=1 with data_in=8'hA3 on the phases 2 and 3 edges -> opcode=3'd5, operand=5'd3 from phase 3 onward.
- halt=1 at phase 4 -> next cycle phase=5, halted=1; phase stays 5 for 20 cycles. Then go=1 -> phase=6, halted=0, then 7, 0.
- halt=1 at phase 2 -> ignored, phase advances to 3. halt=1 and go=1 together at phase 4 -> enters HALTED.
- ld_ac=1 with ac_next=8'h00 -> zero=1. ld_ac=1 with ac_next=8'h01 -> zero=0. ld_ac=0 with ac_next=0 -> zero unchanged (0).
- ena=0 for 3 cycles mid-phase 6 -> all outputs frozen. rst=1 while halted with ena=0 -> phase=0, halted=0, IR=0, zero=1 on the next edge.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC encodings: opcodes, instruction phases and sequencer run state.
package veririsc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/veririsc_phase_counter.sv
// 3-bit instruction phase counter: synchronous reset, load has priority over increment.
module veririsc_phase_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    output logic [2:0] count_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/veririsc_sequencer.sv
// VeriRISC upstream stage: phase sequencing, RUN/HALTED state, instruction register and zero flag.
module veririsc_sequencer
    import veririsc_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int OPWIDTH = 3,
    parameter int AWIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               go,
    input  logic               halt,
    input  logic               ld_ir,
    input  logic               ld_ac,
    input  logic [DWIDTH-1:0]  data_in,
    input  logic [DWIDTH-1:0]  ac_next,
    output logic [2:0]         phase,
    output logic [OPWIDTH-1:0] opcode,
    output logic [AWIDTH-1:0]  operand,
    output logic               zero,
    output logic               halted
);

    if (AWIDTH != DWIDTH - OPWIDTH) begin : g_bad_width
        $error("veririsc_sequencer: AWIDTH must equal DWIDTH - OPWIDTH");
    end

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic              ph_inc;
    logic              ph_load;
    logic [2:0]        ph_val;
    logic [DWIDTH-1:0] ir_q;
    logic              zero_q;

    veririsc_phase_counter u_phase (
        .clk        (clk),
        .rst        (rst),
        .en_i       (ph_inc),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .count_o    (phase)
    );

    // Halting parks on OP_FETCH, where a HLT instruction drives no PC update.
    always_comb begin
        state_d = state_q;
        ph_inc  = 1'b0;
        ph_load = 1'b0;
        ph_val  = '0;
        if (ena) begin
            case (state_q)
                S_RUN: begin
                    if (phase == OP_ADDR && halt) begin
                        state_d = S_HALTED;
                        ph_load = 1'b1;
                        ph_val  = OP_FETCH;
                    end else begin
                        ph_inc = 1'b1;
                    end
                end
                S_HALTED: begin
                    if (go) begin
                        state_d = S_RUN;
                        ph_load = 1'b1;
                        ph_val  = ALU_OP;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= '0;
        end else if (ena && ld_ir) begin
            ir_q <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else if (ena && ld_ac) begin
            zero_q <= (ac_next == '0);
        end
    end

    assign opcode  = ir_q[DWIDTH-1:AWIDTH];
    assign operand = ir_q[AWIDTH-1:0];
    assign zero    = zero_q;
    assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Scoreboard bench for veririsc_sequencer: directed plan followed by random stimulus.
module tb_veririsc_sequencer;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       go;
    logic       halt;
    logic       ld_ir;
    logic       ld_ac;
    logic [7:0] data_in;
    logic [7:0] ac_next;
    logic [2:0] phase;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       zero;
    logic       halted;

    veririsc_sequencer #(.DWIDTH(8), .OPWIDTH(3), .AWIDTH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .go      (go),
        .halt    (halt),
        .ld_ir   (ld_ir),
        .ld_ac   (ld_ac),
        .data_in (data_in),
        .ac_next (ac_next),
        .phase   (phase),
        .opcode  (opcode),
        .operand (operand),
        .zero    (zero),
        .halted  (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         ph;
        logic [7:0] ir;
        bit         z;
        bit         h;
    } exp_t;

    exp_t q[$];
    exp_t x;

    int assertions = 0;
    int failures   = 0;

    // Reference state, updated from the behavioural rules as stimulus is issued.
    int         m_phase = 0;
    bit         m_halted = 0;
    logic [7:0] m_ir = '0;
    bit         m_zero = 1;

    task automatic chk(input string name, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit g, input bit h,
                       input bit li, input bit la, input logic [7:0] d, input logic [7:0] a);
        exp_t n;
        @(negedge clk);
        rst = r; ena = e; go = g; halt = h; ld_ir = li; ld_ac = la;
        data_in = d; ac_next = a;
        if (r) begin
            m_phase = 0; m_halted = 0; m_ir = '0; m_zero = 1;
        end else if (e) begin
            if (!m_halted) begin
                if (m_phase == 4 && h) begin
                    m_halted = 1;
                    m_phase  = 5;
                end else begin
                    m_phase = (m_phase + 1) % 8;
                end
            end else if (g) begin
                m_halted = 0;
                m_phase  = 6;
            end
            if (li) m_ir = d;
            if (la) m_zero = (a == 8'd0);
        end
        n.ph = m_phase; n.ir = m_ir; n.z = m_zero; n.h = m_halted;
        q.push_back(n);
    endtask

    task automatic step();
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h55);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 16 && m_phase != p; i++) step();
        chk("run_to_reached", m_phase, p);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("phase",   int'(phase),   x.ph);
            chk("opcode",  int'(opcode),  int'(x.ir[7:5]));
            chk("operand", int'(operand), int'(x.ir[4:0]));
            chk("zero",    int'(zero),    int'(x.z));
            chk("halted",  int'(halted),  int'(x.h));
        end
    end

    initial begin
        rst = 1; ena = 0; go = 0; halt = 0; ld_ir = 0; ld_ac = 0;
        data_in = '0; ac_next = '0;

        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) step();

        run_to(2);
        cyc(0, 1, 0, 0, 1, 0, 8'hA3, 8'h00);
        cyc(0, 1, 0, 0, 1, 0, 8'hA3, 8'h00);
        cyc(0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) step();
        cyc(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step();

        run_to(2);
        cyc(0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        step();
        cyc(0, 1, 1, 1, 0, 0, 8'h00, 8'h00);
        step();
        cyc(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);

        cyc(0, 1, 0, 0, 0, 1, 8'h00, 8'h00);
        cyc(0, 1, 0, 0, 0, 1, 8'h00, 8'h01);
        cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);

        run_to(6);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 1, 8'hFF, 8'h00);
        run_to(4);
        cyc(0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        cyc(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                8'($urandom),
                ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
